// File: rtl/penc_pkg.sv
// Shared constants and helpers for the prioritised request encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: selection-mode codes, search-direction codes, onehot() helper.
// Optional feature macro used by the top: PENC_OVERFLOW_EN.
package penc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Search direction for penc_select.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Widest request vector onehot() can describe; callers cast down to N.
  localparam int PENC_MAX_N = 1024;

  function automatic logic [PENC_MAX_N-1:0] onehot(input int idx, input int n);
    logic [PENC_MAX_N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < PENC_MAX_N) begin
      v[idx] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/penc_select.sv
// Combinational circular priority pick over an N-bit vector.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: vec (candidates), base (first position examined), dir (DIR_UP/DIR_DOWN),
//        idx (chosen position), found (any bit set in vec).
module penc_select
  import penc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  input  logic         dir,
  output logic [W-1:0] idx,
  output logic         found
);

  int p;

  // Walk the distance from base from farthest to nearest so the nearest hit
  // is the last one written and therefore wins. base is always < N.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dir == DIR_UP) begin
        p = int'(base) + i;
        if (p >= N) p = p - N;
      end else begin
        p = int'(base) - i;
        if (p < 0) p = p + N;
      end
      if (vec[p[W-1:0]]) begin
        idx   = p[W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Collects request bits into a pending set and offers one index at a time.
// Latency: a request sampled at edge t is offered right after edge t if the slot is free.
// Backpressure: idx_o/valid_o hold while valid_o && !ready_i; new requests only queue.
// Ports: clk, rst_n (async active-low), req_i[N], ready_i -> idx_o[W], valid_o, pending_o[N].
// MODE: MODE_FIXED (highest index wins) or MODE_RR (round-robin after last served).
// Macro PENC_OVERFLOW_EN adds ovf_o: sticky flag for a duplicate request that merged away.
module prio_req_encoder
  import penc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] pending_o
`ifdef PENC_OVERFLOW_EN
  ,
  output logic         ovf_o
`endif
);

  logic [N-1:0] pending;
  logic [N-1:0] pending_next;
  logic [N-1:0] clr;
  logic         valid;
  logic [W-1:0] idx;
  logic         transfer;
  logic         load;
  logic [W-1:0] base;
  logic         dir;
  logic [W-1:0] sel_idx;
  logic         sel_found;

  assign transfer = valid & ready_i;
  assign clr      = transfer ? N'(onehot(int'(idx), N)) : '0;
  // A fresh request on the bit being consumed is OR-ed back in, so it survives.
  assign pending_next = (pending & ~clr) | req_i;
  assign load         = ~valid | ready_i;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [W-1:0] last;
      logic [W-1:0] eff_last;

      // On a transfer the served index becomes "last" at this same edge, so the
      // next pick must already start after it.
      assign eff_last = transfer ? idx : last;
      assign base     = (eff_last == W'(N - 1)) ? '0 : eff_last + W'(1);
      assign dir      = DIR_UP;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last <= W'(N - 1);
        end else if (transfer) begin
          last <= idx;
        end
      end
    end else begin : g_fixed
      assign base = W'(N - 1);
      assign dir  = DIR_DOWN;
    end
  endgenerate

  penc_select #(
    .N (N),
    .W (W)
  ) u_select (
    .vec   (pending_next),
    .base  (base),
    .dir   (dir),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // The offered bit remains in pending until its own transfer clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      valid   <= 1'b0;
      idx     <= '0;
    end else begin
      pending <= pending_next;
      if (load) begin
        valid <= sel_found;
        if (sel_found) begin
          idx <= sel_idx;
        end
      end
    end
  end

`ifdef PENC_OVERFLOW_EN
  logic ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (|(req_i & pending & ~clr)) begin
      ovf <= 1'b1;
    end
  end

  assign ovf_o = ovf;
`endif

  assign idx_o     = idx;
  assign valid_o   = valid;
  assign pending_o = pending;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Bench for prio_req_encoder: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// driven by directed sequences and random traffic, compared against a set-based model.
// Optional checks for ovf_o compile in when PENC_OVERFLOW_EN is defined.
module tb_prio_req_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req0, req1;
  logic [4:0] req2;
  logic       rdy0, rdy1, rdy2;
  logic [2:0] idx0, idx1, idx2;
  logic       vld0, vld1, vld2;
  logic [7:0] pend0, pend1;
  logic [4:0] pend2;
`ifdef PENC_OVERFLOW_EN
  logic       ovf0, ovf1, ovf2;
`endif

  prio_req_encoder #(.N(8), .MODE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .idx_o(idx0), .valid_o(vld0),
    .ready_i(rdy0), .pending_o(pend0)
`ifdef PENC_OVERFLOW_EN
    , .ovf_o(ovf0)
`endif
  );

  prio_req_encoder #(.N(8), .MODE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .idx_o(idx1), .valid_o(vld1),
    .ready_i(rdy1), .pending_o(pend1)
`ifdef PENC_OVERFLOW_EN
    , .ovf_o(ovf1)
`endif
  );

  prio_req_encoder #(.N(5), .MODE(1)) d2 (
    .clk(clk), .rst_n(rst_n), .req_i(req2), .idx_o(idx2), .valid_o(vld2),
    .ready_i(rdy2), .pending_o(pend2)
`ifdef PENC_OVERFLOW_EN
    , .ovf_o(ovf2)
`endif
  );

  int tests = 0;
  int failed = 0;

  // Reference model: a pending set, the offered slot and the round-robin pointer.
  int         nn[3] = '{8, 8, 5};
  int         md[3] = '{0, 1, 1};
  logic [7:0] mreq[3];
  logic       mrdy[3];
  logic [7:0] mp[3];
  logic       mv[3];
  int         mi[3];
  int         ml[3];
  logic       movf[3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mp[d]   = '0;
      mv[d]   = 1'b0;
      mi[d]   = 0;
      ml[d]   = nn[d] - 1;
      movf[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int  n;
    int  pick;
    bit  trans;
    n     = nn[d];
    trans = mv[d] && mrdy[d];
    for (int k = 0; k < n; k++) begin
      if (mreq[d][k] && mp[d][k] && !(trans && k == mi[d])) movf[d] = 1'b1;
    end
    if (trans) mp[d][mi[d]] = 1'b0;
    mp[d] = mp[d] | mreq[d];
    if (trans && md[d] == 1) ml[d] = mi[d];
    if (!mv[d] || mrdy[d]) begin
      pick = -1;
      if (md[d] == 0) begin
        for (int k = 0; k < n; k++) if (mp[d][k]) pick = k;
      end else begin
        for (int s = n; s >= 1; s--) if (mp[d][(ml[d] + s) % n]) pick = (ml[d] + s) % n;
      end
      mv[d] = (pick >= 0);
      if (pick >= 0) mi[d] = pick;
    end
  endtask

  task automatic check_all(input string phase);
    logic [31:0] ov[3];
    logic [31:0] oi[3];
    logic [31:0] op[3];
    ov[0] = 32'(vld0);  ov[1] = 32'(vld1);  ov[2] = 32'(vld2);
    oi[0] = 32'(idx0);  oi[1] = 32'(idx1);  oi[2] = 32'(idx2);
    op[0] = 32'(pend0); op[1] = 32'(pend1); op[2] = 32'(pend2);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_d%0d_valid", phase, d), ov[d], 32'(mv[d]));
      check_eq($sformatf("%s_d%0d_idx", phase, d), oi[d], 32'(mi[d]));
      check_eq($sformatf("%s_d%0d_pending", phase, d), op[d], 32'(mp[d]));
    end
`ifdef PENC_OVERFLOW_EN
    check_eq($sformatf("%s_d0_ovf", phase), 32'(ovf0), 32'(movf[0]));
    check_eq($sformatf("%s_d1_ovf", phase), 32'(ovf1), 32'(movf[1]));
    check_eq($sformatf("%s_d2_ovf", phase), 32'(ovf2), 32'(movf[2]));
`endif
  endtask

  task automatic drive(input int d, input logic [7:0] r, input logic rd);
    logic [7:0] m;
    m = (d == 2) ? 8'h1f : 8'hff;
    mreq[d] = r & m;
    mrdy[d] = rd;
    case (d)
      0: begin req0 = r; rdy0 = rd; end
      1: begin req1 = r; rdy1 = rd; end
      default: begin req2 = r[4:0]; rdy2 = rd; end
    endcase
  endtask

  task automatic drive_all(input logic [7:0] r, input logic rd);
    for (int d = 0; d < 3; d++) drive(d, r, rd);
  endtask

  task automatic tick(input string phase);
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_all(phase);
  endtask

  // Asserts reset away from any clock edge and checks that outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_all(8'h00, 1'b0);
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive_all(8'h00, 1'b0);
    model_reset();
    #3;
    do_reset();

    // Fixed priority: two bits, highest first, then drain.
    drive_all(8'b1000_0100, 1'b1);
    tick("fix_a");
    check_eq("fix_first_idx", 32'(idx0), 32'd7);
    check_eq("fix_first_valid", 32'(vld0), 32'd1);
    drive_all(8'h00, 1'b1);
    tick("fix_b");
    check_eq("fix_second_idx", 32'(idx0), 32'd2);
    tick("fix_c");
    check_eq("fix_drained_valid", 32'(vld0), 32'd0);
    check_eq("fix_drained_pending", 32'(pend0), 32'd0);

    // Stall with idx 2 offered; a higher request must not preempt it.
    do_reset();
    drive_all(8'b0000_0100, 1'b0);
    tick("hold_a");
    drive_all(8'b0100_0000, 1'b0);
    tick("hold_b");
    check_eq("hold_no_preempt", 32'(idx0), 32'd2);
    drive_all(8'h00, 1'b0);
    tick("hold_c");
    check_eq("hold_still_2", 32'(idx0), 32'd2);
    check_eq("hold_pending", 32'(pend0), 32'h44);
    drive_all(8'h00, 1'b1);
    tick("hold_d");
    check_eq("hold_then_6", 32'(idx0), 32'd6);
    tick("hold_e");

    // Round-robin with a held request pattern wraps 0,2,5,0,2,5.
    do_reset();
    drive_all(8'b0010_0101, 1'b1);
    for (int i = 0; i < 6; i++) begin
      int exp_seq[6] = '{0, 2, 5, 0, 2, 5};
      tick("rr");
      check_eq($sformatf("rr_seq%0d", i), 32'(idx1), 32'(exp_seq[i]));
    end
    drive_all(8'h00, 1'b1);
    repeat (4) tick("rr_drain");

    // Transfer of idx 3 while req_i[3] is asserted again.
    do_reset();
    drive_all(8'b0000_1000, 1'b0);
    tick("coll_a");
    drive_all(8'b0000_1000, 1'b1);
    tick("coll_b");
    check_eq("coll_pending3", 32'(pend0[3]), 32'd1);
    check_eq("coll_reoffer", 32'(idx0), 32'd3);
    check_eq("coll_valid", 32'(vld0), 32'd1);
    drive_all(8'h00, 1'b1);
    tick("coll_c");
    check_eq("coll_done", 32'(vld0), 32'd0);

    // N=5: top index, then reset while it is on offer.
    do_reset();
    drive_all(8'b0001_0000, 1'b0);
    tick("n5");
    check_eq("n5_idx4", 32'(idx2), 32'd4);
    check_eq("n5_valid", 32'(vld2), 32'd1);
    do_reset();
    check_eq("n5_rst_valid", 32'(vld2), 32'd0);
    check_eq("n5_rst_pending", 32'(pend2), 32'd0);

`ifdef PENC_OVERFLOW_EN
    drive_all(8'b0000_0010, 1'b0);
    tick("ovf_a");
    drive_all(8'b0000_0010, 1'b0);
    tick("ovf_b");
    check_eq("ovf_set", 32'(ovf0), 32'd1);
    drive_all(8'h00, 1'b1);
    repeat (3) tick("ovf_c");
    check_eq("ovf_sticky", 32'(ovf0), 32'd1);
    do_reset();
    check_eq("ovf_cleared", 32'(ovf0), 32'd0);
`endif

    // Random traffic on all three instances.
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < 3; d++) begin
        logic [7:0] r;
        logic       rd;
        r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        rd = ($urandom_range(0, 9) < 7);
        drive(d, r, rd);
      end
      tick("rand");
      if (c == 400) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
